apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Round-robin APB master that shares one APB bus between NUM_REQ internal requesters. It accepts word requests over a per-requester valid/ready handshake and sequences the APB SETUP and ACCESS phases toward the slave. It waits for PREADY and returns a registered per-requester response. It sits on the TEST side of the APB interface, in place of the bench driver, and drives PADDR/PSELx/PWRITE/PWDATA/PENABLE while sampling PREADY/PRDATA.

## Interface
- ADDR_WIDTH, 16, APB address width
- DATA_WIDTH, 32, APB data width
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed; slice i = requester i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid
- resp_err  out  1  timeout flag, valid with resp_valid
- busy  out  1  high in SETUP or ACCESS
- PADDR  out  ADDR_WIDTH  APB address
- PSELx  out  1  APB select
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PENABLE  out  1  APB enable
- PREADY  in  1  slave ready
- PRDATA  in  DATA_WIDTH  slave read data

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid is high, grant one requester (pulse req_ready[i]), register its write/addr/wdata, then go to SETUP. Otherwise stay in IDLE.
- SETUP: PSELx=1, PENABLE=0; the APB outputs carry the registered request. Always goes to ACCESS on the next cycle.
- ACCESS: PSELx=1, PENABLE=1, outputs held stable.
  - PREADY=0: stay in ACCESS.
  - PREADY=1: the transfer completes that cycle. Capture PRDATA for a read; capture 0 for a write.
  - Arbitration also runs in the completing cycle. If a request is granted, go to SETUP (back-to-back). Otherwise go to IDLE.
- Arbitration is round-robin. Search starts at index (last_grant+1) mod NUM_REQ. After reset the pointer makes requester 0 highest priority. The pointer updates only on a grant.
- Requester protocol: hold req_valid and the request fields stable until req_ready. Deasserting req_valid before the grant is legal; that request is then never issued.
- A requester whose transfer is completing may be granted again in the same cycle, but only if no other requester is pending ahead of it in round-robin order.
- In IDLE, PSELx=0 and PENABLE=0. PADDR/PWRITE/PWDATA keep their last values.

## Timing
- Reset values: all outputs 0; state IDLE; grant pointer 0; timeout counter 0.
- Grant in cycle T: SETUP in T+1, first ACCESS in T+2.
- PREADY high in cycle Ta: resp_valid[i], resp_rdata and resp_err are registered and valid in Ta+1 for exactly one cycle.
- Zero-wait transfer: 3 cycles from grant to resp_valid. Back-to-back throughput is one transfer every 2 cycles.
- Each wait state (PREADY=0 in ACCESS) adds one cycle.
- PRESET asserted mid-transfer: outputs clear immediately (asynchronously) and the in-flight transfer is dropped with no resp_valid. After release, the block starts in IDLE.
- If several requesters assert req_valid in the same cycle, only the round-robin winner gets req_ready; the others stay pending.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter runs in ACCESS. If PREADY is still 0 after TIMEOUT_CYCLES ACCESS cycles, the block aborts the transfer.
  - Abort: PSELx and PENABLE go to 0 in the next cycle, and resp_valid[i] pulses with resp_err=1 and resp_rdata=0.
  - Arbitration then proceeds as for a normal completion.
  - PREADY=1 on the final allowed cycle counts as a normal completion.
- APB_TIMEOUT_EN undefined: no counter exists, ACCESS waits indefinitely, and resp_err is tied to 0.

## Test plan
- Single read, requester 2, addr 0x0040, slave returns 0xDEADBEEF with PREADY=1 and no wait states -> req_ready=4'b0100 at T; SETUP at T+1; ACCESS at T+2; resp_valid=4'b0100, resp_rdata=0xDEADBEEF at T+3.
- Write, requester 0, addr 0x1234, data 0xA5A5A5A5, slave inserts 3 wait states -> PADDR/PWDATA/PWRITE stable throughout; PENABLE high for 4 cycles; resp_valid at T+6; resp_rdata=0.
- All 4 requesters hold req_valid continuously from reset -> grants in order 0,1,2,3,0, one every 2 cycles; PSELx never drops between transfers.
- Requester 1 holds req_valid during requester 3's transfer; requester 3 re-requests on its completion cycle -> requester 1 is granted next, not 3.
- PRESET pulsed during ACCESS of requester 0 -> PSELx, PENABLE and busy are 0 immediately; no resp_valid; a new request after release completes normally.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 ACCESS cycles; resp_err=1; resp_rdata=0; next pending request is granted. Without the macro, the block is still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between apb_master_arbiter (master) and the slave side.
// The master modport drives the request phase; the slave modport answers it.
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSELx;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PENABLE;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    output PADDR, PSELx, PWRITE, PWDATA, PENABLE,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PADDR, PSELx, PWRITE, PWDATA, PENABLE,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master sharing one APB bus between NUM_REQ requesters.
// Optional ACCESS-phase timeout abort is enabled with the APB_TIMEOUT_EN macro.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          resp_err,
  output logic                          busy,
  apb_master_arbiter_if.master          apb
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         grant_idx;
  logic [IW:0]           cand;
  logic                  grant_found;
  logic                  grant;
  logic                  done;
  logic                  timeout_hit;
  logic                  psel;
  logic                  penable;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Completion: slave ready, or the ACCESS phase ran out of time.
  assign done  = (state == ACCESS) && (apb.PREADY || timeout_hit);
  assign grant = grant_found && ((state == IDLE) || done);

  // Round-robin search from rr_ptr; the lowest offset with a pending request wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand        = {1'b0, rr_ptr} + (IW+1)'(k);
      cand        = (cand >= (IW+1)'(NUM_REQ)) ? cand - (IW+1)'(NUM_REQ) : cand;
      grant_idx   = req_valid[cand[IW-1:0]] ? cand[IW-1:0] : grant_idx;
      grant_found = grant_found | req_valid[cand[IW-1:0]];
    end
  end

  always_comb begin
    req_ready = grant ? onehot(grant_idx) : '0;
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Counts ACCESS cycles of the current transfer; cleared whenever it ends.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      to_cnt <= '0;
    end else if ((state == ACCESS) && !done) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout_hit = (state == ACCESS) && !apb.PREADY &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a grant in the completing cycle chains straight into SETUP.
  always_comb begin
    case (state)
      IDLE:    next_state = grant ? SETUP : IDLE;
      SETUP:   next_state = ACCESS;
      ACCESS:  next_state = done ? (grant ? SETUP : IDLE) : ACCESS;
      default: next_state = IDLE;
    endcase
  end

  // APB phase outputs decoded from the state register.
  always_comb begin
    case (state)
      IDLE:    begin psel = 1'b0; penable = 1'b0; busy = 1'b0; end
      SETUP:   begin psel = 1'b1; penable = 1'b0; busy = 1'b1; end
      ACCESS:  begin psel = 1'b1; penable = 1'b1; busy = 1'b1; end
      default: begin psel = 1'b0; penable = 1'b0; busy = 1'b0; end
    endcase
  end

  // Request capture and pointer advance; fields persist into IDLE.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rr_ptr  <= '0;
      owner   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      rr_ptr  <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      owner   <= grant_idx;
      write_q <= req_write[grant_idx];
      addr_q  <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_q <= req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      rr_ptr  <= rr_ptr;
      owner   <= owner;
      write_q <= write_q;
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
    end
  end

  // One-cycle response; writes and aborted transfers return zero data.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= done ? onehot(owner) : '0;
      resp_rdata <= (done && !write_q && !timeout_hit) ? apb.PRDATA : '0;
      resp_err   <= done && timeout_hit;
    end
  end

  assign apb.PADDR   = addr_q;
  assign apb.PWRITE  = write_q;
  assign apb.PWDATA  = wdata_q;
  assign apb.PSELx   = psel;
  assign apb.PENABLE = penable;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus random
// traffic, checked against a transaction-timeline reference model.
module tb_apb_master_arbiter;
  localparam int N       = 4;
  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic            PCLK;
  logic            PRESET;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic            busy;

  apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_master_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .apb(apb)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // stimulus state
  logic [N-1:0]  rv = '0;
  logic [N-1:0]  rw = '0;
  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  bit            hold_all = 1'b0;

  // reference model state
  bit            active = 1'b0;
  int            gcyc = 0;
  int            owner = 0;
  int            ptr = 0;
  bit            cur_write = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  bit            resp_due = 1'b0;
  int            resp_idx = 0;
  logic [DW-1:0] resp_data = '0;
  bit            resp_err_exp = 1'b0;

  // last sampled outputs for directed checks
  logic [N-1:0]  obs_rdy;
  logic [N-1:0]  obs_rvalid;
  logic [DW-1:0] obs_rdata;
  logic          obs_err;
  logic          obs_psel;
  logic          obs_pen;
  logic          obs_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    req_valid = rv;
    req_write = rw;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = ra[i];
      req_wdata[i*DW +: DW] = rd[i];
    end
    apb.PREADY = pready;
    apb.PRDATA = prdata;
  endtask

  // One clock cycle: drive inputs after the edge, sample mid-cycle, compare, advance model.
  task automatic tick();
    bit in_access;
    bit timed_out;
    bit completing;
    int w;
    logic [N-1:0] exp_rdy;
    @(posedge PCLK);
    #1;
    drive();
    #2;
    cyc++;
    obs_rdy = req_ready; obs_rvalid = resp_valid; obs_rdata = resp_rdata;
    obs_err = resp_err; obs_psel = apb.PSELx; obs_pen = apb.PENABLE; obs_busy = busy;

    in_access = active && (cyc >= gcyc + 2);
    timed_out = 1'b0;
`ifdef APB_TIMEOUT_EN
    timed_out = in_access && !pready && ((cyc - gcyc - 1) == TIMEOUT);
`endif
    completing = in_access && (pready || timed_out);

    check("resp_valid", resp_valid, resp_due ? (N'(1) << resp_idx) : '0);
    if (resp_due) begin
      check("resp_rdata", resp_rdata, resp_data);
      check("resp_err", resp_err, resp_err_exp);
    end
    check("PSELx", apb.PSELx, active);
    check("PENABLE", apb.PENABLE, in_access);
    check("busy", busy, active);
    if (active) begin
      check("PADDR", apb.PADDR, cur_addr);
      check("PWRITE", apb.PWRITE, cur_write);
      if (cur_write) check("PWDATA", apb.PWDATA, cur_wdata);
    end
    w = (!active || completing) ? rr_pick(rv, ptr) : -1;
    exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
    check("req_ready", req_ready, exp_rdy);

    resp_due     = completing;
    resp_idx     = owner;
    resp_data    = (cur_write || timed_out) ? '0 : prdata;
    resp_err_exp = timed_out;
    if (completing) active = 1'b0;
    if (w >= 0) begin
      active    = 1'b1;
      gcyc      = cyc;
      owner     = w;
      cur_write = rw[w];
      cur_addr  = ra[w];
      cur_wdata = rd[w];
      ptr       = (w + 1) % N;
      if (!hold_all) rv[w] = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    #1;
    rv = '0;
    pready = 1'b0;
    drive();
    PRESET = 1'b1;
    #1;
    check("rst_PSELx", apb.PSELx, 1'b0);
    check("rst_PENABLE", apb.PENABLE, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, '0);
    active = 1'b0; resp_due = 1'b0; ptr = 0;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  task automatic drain();
    pready = 1'b1;
    for (int k = 0; k < 40 && (active || resp_due || rv != '0); k++) tick();
    check("drain_idle", obs_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pen_cnt;
    int psel_low;
    int grants [$];
    for (int i = 0; i < N; i++) begin ra[i] = '0; rd[i] = '0; end
    PRESET = 1'b1;
    drive();
    #3;
    check("reset_req_ready", req_ready, '0);
    check("reset_resp_valid", resp_valid, '0);
    check("reset_resp_rdata", resp_rdata, '0);
    check("reset_resp_err", resp_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_PADDR", apb.PADDR, '0);
    check("reset_PSELx", apb.PSELx, 1'b0);
    check("reset_PWRITE", apb.PWRITE, 1'b0);
    check("reset_PWDATA", apb.PWDATA, '0);
    check("reset_PENABLE", apb.PENABLE, 1'b0);
    @(posedge PCLK); #1; PRESET = 1'b0;

    // single zero-wait read from requester 2
    ra[2] = 16'h0040; rw[2] = 1'b0; rv[2] = 1'b1;
    tick(); check("rd_grant", obs_rdy, 4'b0100);
    tick(); check("rd_setup", {obs_psel, obs_pen}, 2'b10);
    pready = 1'b1; prdata = 32'hDEADBEEF;
    tick(); check("rd_access", {obs_psel, obs_pen}, 2'b11);
    pready = 1'b0;
    tick(); check("rd_resp_valid", obs_rvalid, 4'b0100);
    check("rd_resp_rdata", obs_rdata, 32'hDEADBEEF);

    // write from requester 0 with three wait states
    ra[0] = 16'h1234; rd[0] = 32'hA5A5A5A5; rw[0] = 1'b1; rv[0] = 1'b1;
    tick(); check("wr_grant", obs_rdy, 4'b0001);
    tick();
    pen_cnt = 0;
    repeat (3) begin tick(); pen_cnt += int'(obs_pen); end
    pready = 1'b1; prdata = 32'h12345678;
    tick(); pen_cnt += int'(obs_pen);
    pready = 1'b0;
    tick(); check("wr_resp_valid", obs_rvalid, 4'b0001);
    check("wr_resp_rdata", obs_rdata, 32'h0);
    check("wr_penable_cycles", pen_cnt, 4);

    // all four requesters hold valid from reset
    pulse_reset();
    for (int i = 0; i < N; i++) begin ra[i] = AW'(16'h0100 + i); rw[i] = 1'b0; end
    hold_all = 1'b1; rv = 4'b1111; pready = 1'b1;
    psel_low = 0;
    for (int k = 0; k < 9; k++) begin
      prdata = DW'(32'hC0DE0000 + k);
      tick();
      if (obs_rdy != '0) for (int i = 0; i < N; i++) if (obs_rdy[i]) grants.push_back(i);
      if (k > 0 && !obs_psel) psel_low++;
    end
    check("rr_grant_count", grants.size(), 5);
    for (int g = 0; g < grants.size() && g < 5; g++) check("rr_grant_order", grants[g], g % N);
    check("rr_psel_drops", psel_low, 0);
    hold_all = 1'b0; rv = '0;
    drain();

    // requester 3 re-requests on completion while requester 1 waits
    pready = 1'b0;
    ra[3] = 16'h0333; rw[3] = 1'b0; rv[3] = 1'b1;
    tick(); check("rr3_grant", obs_rdy, 4'b1000);
    ra[1] = 16'h0111; rw[1] = 1'b1; rd[1] = 32'h11111111; rv[1] = 1'b1;
    tick();
    rv[3] = 1'b1; pready = 1'b1; prdata = 32'h33333333;
    tick(); check("rr_fair_grant", obs_rdy, 4'b0010);
    drain();

    // reset during ACCESS of requester 0
    pready = 1'b0;
    ra[0] = 16'h0050; rw[0] = 1'b0; rv[0] = 1'b1;
    tick(); tick(); tick(); tick();
    pulse_reset();
    ra[0] = 16'h0ABC; rw[0] = 1'b0; rv[0] = 1'b1; pready = 1'b1; prdata = 32'h0F0F0F0F;
    tick(); check("post_rst_grant", obs_rdy, 4'b0001);
    drain();

    // ACCESS held with PREADY low
    pready = 1'b0;
    ra[1] = 16'h0A01; rw[1] = 1'b0; rv[1] = 1'b1;
    ra[2] = 16'h0A02; rw[2] = 1'b0; rv[2] = 1'b1;
    tick(); check("to_first_grant", obs_rdy, 4'b0010);
`ifdef APB_TIMEOUT_EN
    repeat (1 + TIMEOUT) tick();
    check("to_regrant", obs_rdy, 4'b0100);
    tick();
    check("to_resp_valid", obs_rvalid, 4'b0010);
    check("to_resp_err", obs_err, 1'b1);
    check("to_resp_rdata", obs_rdata, 32'h0);
`else
    tick();
    repeat (100) tick();
    check("wait_still_access", {obs_psel, obs_pen}, 2'b11);
    check("wait_no_resp", obs_rvalid, 4'b0000);
`endif
    drain();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1;
          rw[i] = 1'($urandom_range(0, 1));
          ra[i] = AW'($urandom);
          rd[i] = $urandom;
        end else if (rv[i] && $urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0;
        end
      end
      pready = ($urandom_range(0, 2) != 0);
      prdata = $urandom;
      tick();
    end
    rv = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
